// File: rtl/name_stream_loader_if.sv
// rtl/name_stream_loader_if.sv - name word input and parallel name output bundle
//
// Purpose: groups the word-serial input handshake, the FIFO head outputs and
// the status counters of name_stream_loader.
// Ports (signals):
//   in_valid/in_ready/in_data/in_last : word-serial name input
//   out_valid/out_ready               : FIFO head handshake
//   out_name/out_len/out_trunc/out_hash : head name fields
//   fifo_count/trunc_count            : status
// Modports: master = source/consumer side, slave = loader side.
interface name_stream_loader_if #(
  parameter int WORD_SIZE       = 64,
  parameter int MAX_NAME_LENGTH = 16,
  parameter int NAME_DEPTH      = 4,
  parameter int HASH_SIZE       = 16
) ();
  logic                                 in_valid;
  logic                                 in_ready;
  logic [WORD_SIZE-1:0]                 in_data;
  logic                                 in_last;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] out_name;
  logic [$clog2(MAX_NAME_LENGTH+1)-1:0] out_len;
  logic                                 out_trunc;
  logic [HASH_SIZE-1:0]                 out_hash;
  logic [$clog2(NAME_DEPTH+1)-1:0]      fifo_count;
  logic [15:0]                          trunc_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_name, out_len, out_trunc, out_hash,
           fifo_count, trunc_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_name, out_len, out_trunc, out_hash,
           fifo_count, trunc_count
  );
endinterface

// File: rtl/name_stream_loader.sv
// rtl/name_stream_loader.sv - assembles word-serial names into a FWFT name FIFO
//
// Purpose: collects last-flagged WORD_SIZE-bit words into a zero-padded
// MAX_NAME_LENGTH-word vector, commits it with its length, truncation flag and
// optional hash into a NAME_DEPTH-entry first-word-fall-through FIFO.
// Optional feature macro: NAME_LOADER_HASH_EN (XOR-fold hash per name).
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : name_stream_loader_if.slave (input words, head name, status)
module name_stream_loader #(
  parameter int WORD_SIZE       = 64,
  parameter int MAX_NAME_LENGTH = 16,
  parameter int NAME_DEPTH      = 4,
  parameter int HASH_SIZE       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  name_stream_loader_if.slave  bus
);
  localparam int LEN_W  = $clog2(MAX_NAME_LENGTH + 1);
  localparam int PTR_W  = $clog2(NAME_DEPTH);
  localparam int CNT_W  = $clog2(NAME_DEPTH + 1);
  localparam int NAME_W = MAX_NAME_LENGTH * WORD_SIZE;

  typedef enum logic {S_COLLECT, S_COMMIT} state_t;

  state_t r_state, w_next_state;

  logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0] r_buf;
  logic [LEN_W-1:0]  r_widx;
  logic              r_trunc;

  logic [NAME_W-1:0] r_fifo_name  [NAME_DEPTH];
  logic [LEN_W-1:0]  r_fifo_len   [NAME_DEPTH];
  logic              r_fifo_trunc [NAME_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [15:0]       r_trunc_count;

  logic w_in_ready, w_in_fire, w_out_valid, w_pop, w_push;

  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && bus.out_ready;
  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign w_push      = (r_state == S_COMMIT) &&
                       ((r_count != CNT_W'(NAME_DEPTH)) || w_pop);
  assign w_in_fire   = bus.in_valid && w_in_ready;

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) w_next_state = S_COMMIT;
      end
      S_COMMIT: begin
        if (w_push) w_next_state = S_COLLECT;
      end
      default: w_next_state = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
      r_buf   <= '0;
      r_widx  <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_push) begin
        r_buf   <= '0;
        r_widx  <= '0;
        r_trunc <= 1'b0;
      end else if (w_in_fire) begin
        if (r_widx < LEN_W'(MAX_NAME_LENGTH)) begin
          for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
            if (r_widx == LEN_W'(i)) r_buf[i] <= bus.in_data;
          end
          r_widx <= r_widx + LEN_W'(1);
        end else begin
          // Words beyond the vector are dropped; only the flag survives.
          r_trunc <= 1'b1;
        end
      end
    end
  end

  // FIFO storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_name[r_wptr]  <= r_buf;
      r_fifo_len[r_wptr]   <= r_widx;
      r_fifo_trunc[r_wptr] <= r_trunc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_trunc_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && r_trunc && (r_trunc_count != 16'hFFFF))
        r_trunc_count <= r_trunc_count + 16'd1;
    end
  end

`ifdef NAME_LOADER_HASH_EN
  localparam int NCHUNK = (WORD_SIZE + HASH_SIZE - 1) / HASH_SIZE;

  logic [HASH_SIZE-1:0] r_hash;
  logic [HASH_SIZE-1:0] r_fifo_hash [NAME_DEPTH];

  // XOR of all HASH_SIZE-bit chunks of a word, top chunk zero-padded.
  function automatic logic [HASH_SIZE-1:0] fold(input logic [WORD_SIZE-1:0] w);
    logic [NCHUNK*HASH_SIZE-1:0] p;
    logic [HASH_SIZE-1:0]        h;
    p = '0;
    p[WORD_SIZE-1:0] = w;
    h = '0;
    for (int i = 0; i < NCHUNK; i++) h = h ^ p[i*HASH_SIZE +: HASH_SIZE];
    return h;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hash <= '0;
    end else if (w_push) begin
      r_hash <= '0;
    end else if (w_in_fire && (r_widx < LEN_W'(MAX_NAME_LENGTH))) begin
      r_hash <= r_hash ^ fold(bus.in_data);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_hash[r_wptr] <= r_hash;
  end

  assign bus.out_hash = w_out_valid ? r_fifo_hash[r_rptr] : '0;
`else
  assign bus.out_hash = {HASH_SIZE{1'b0}};
`endif

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_name    = w_out_valid ? r_fifo_name[r_rptr]  : '0;
  assign bus.out_len     = w_out_valid ? r_fifo_len[r_rptr]   : '0;
  assign bus.out_trunc   = w_out_valid ? r_fifo_trunc[r_rptr] : 1'b0;
  assign bus.fifo_count  = r_count;
  assign bus.trunc_count = r_trunc_count;
endmodule

// File: doc/name_stream_loader.md
Name: name_stream_loader

Overview:
- Converts a word-serial name stream (WORD_SIZE-bit words, last-flagged) into complete, zero-padded, parallel name vectors for the FIB lookup pipeline (top).
- Buffers up to NAME_DEPTH assembled names in a first-word-fall-through name FIFO.
- Replaces the file-driven name feeding in simulation with a synthesizable, back-pressured source, generalised in word width, name length and buffer depth.
- Reports names that exceed MAX_NAME_LENGTH.

Parameters:
- WORD_SIZE, 64: bits per name word.
- MAX_NAME_LENGTH, 16: maximum name length in words; width of the parallel output vector.
- NAME_DEPTH, 4: name FIFO entries, ≥2, power of 2.
- HASH_SIZE, 16: width of the optional name hash.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  WORD_SIZE  name word.
- in_last  in  1  final word of the current name.
- out_valid  out  1  FIFO head holds a name.
- out_ready  in  1  consumer accepts the head name.
- out_name  out  MAX_NAME_LENGTH*WORD_SIZE  head name; word i at bits [i*WORD_SIZE +: WORD_SIZE]; unused words zero.
- out_len  out  $clog2(MAX_NAME_LENGTH+1)  number of stored words in head name (1..MAX_NAME_LENGTH).
- out_trunc  out  1  head name was truncated.
- out_hash  out  HASH_SIZE  XOR-fold hash of head name (see Optional Feature).
- fifo_count  out  $clog2(NAME_DEPTH+1)  names currently buffered.
- trunc_count  out  16  running count of truncated names, saturating at 0xFFFF.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to COLLECT; write index = 0; assembly buffer zeroed.
  - FIFO is emptied.
  - Output reset values: out_valid=0, fifo_count=0, trunc_count=0, out_name=0, out_len=0, out_trunc=0, out_hash=0, in_ready=1.
  - Reset mid-name discards the partial name; no partial name is ever committed.
- Input handshake: a word is transferred on a rising edge with in_valid && in_ready. in_data and in_last are ignored when in_valid=0.
- FSM COLLECT (in_ready=1):
  - While widx < MAX_NAME_LENGTH, each accepted word is written to assembly word widx, then widx increments.
  - Words accepted while widx == MAX_NAME_LENGTH are dropped and the trunc flag is set.
  - On the edge accepting in_last=1, go to COMMIT. The length stored is min(words received, MAX_NAME_LENGTH).
- FSM COMMIT (in_ready=0):
  - Push {name, len, trunc, hash} into the FIFO on the first edge where fifo_count < NAME_DEPTH, or where a pop occurs on that same edge (simultaneous push and pop when full is legal; count stays NAME_DEPTH).
  - On push: clear the assembly buffer to zero, widx=0, trunc=0, return to COLLECT.
  - If trunc was set, increment trunc_count (saturating).
  - COMMIT holds indefinitely while the FIFO is full and not popping.
- Latency:
  - Last word accepted at edge E0; push at edge E1 at the earliest; out_valid=1 after E1 if the FIFO was empty.
  - Each name costs exactly one in_ready bubble cycle (COMMIT).
  - Sustained throughput is L+1 cycles per L-word name.
- Output side:
  - FWFT: out_* reflect the FIFO head whenever out_valid=1.
  - Pop on out_valid && out_ready; out_ready with an empty FIFO has no effect.
  - out_* hold stable while out_valid && !out_ready.
  - When the FIFO is empty, out_* data fields read 0.
- FIFO pointers are $clog2(NAME_DEPTH) bits and wrap modulo NAME_DEPTH. fifo_count = pushes − pops, held in the range 0..NAME_DEPTH.
- A single-word name (in_last on the first word) gives out_len=1, with words 1..MAX-1 zero.

Optional Feature:
- NAME_LOADER_HASH_EN defined:
  - Running hash register, cleared at commit/reset.
  - Each stored word is split into HASH_SIZE chunks (zero-padding the top chunk) and all chunks are XORed in; truncated words are not included.
  - The hash is stored per FIFO entry and driven on out_hash.
- Macro undefined: no hash logic or FIFO storage; out_hash is constant 0.

Test Plan:
- Single name: words 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out_valid 1 cycle after COMMIT, out_len=3, words 0..2 = 0x11,0x22,0x33, words 3..15 = 0, out_trunc=0.
- Overflow: 18-word name with MAX_NAME_LENGTH=16 -> out_len=16, out_trunc=1, trunc_count=1, words 16–17 absent, in_ready=1 throughout the 18 word beats.
- Backpressure: out_ready=0, push five 1-word names with NAME_DEPTH=4 -> fifo_count=4, in_ready=0 in COMMIT for name 5. Raise out_ready for one cycle -> simultaneous pop/push, fifo_count stays 4, head = name 2.
- Reset mid-name: assert rst after 2 words of a 5-word name, release, send 1-word name 0xAB -> out_len=1, word0=0xAB, fifo_count=1, no stale words.
- Hash (NAME_LOADER_HASH_EN, HASH_SIZE=16): name {0x0001_0002_0003_0004, 0x0000_0000_0000_0004} -> out_hash=0x0000. Without macro -> out_hash=0.
